button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Conditions the raw `up_down` push-button/switch input before it reaches `simple_counter`.
- Synchronises the raw pin to `clk` and debounces it with a 4-state FSM.
- Produces a clean level, single-cycle rise and fall pulses, and a press-toggled direction bit.
- Instantiated in `top`, directly upstream of `simple_counter`. Either `btn_level` or `dir_toggle` drives `simple_counter.up_down`.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised cycles required before the output level changes. Minimum 2; elaboration error below that.
- SYNC_STAGES, 2: flip-flops in the synchroniser chain. Minimum 2.
- ACTIVE_LOW_IN, 1: 1 means the raw pin is inverted before the synchroniser, so a pressed active-low key reads as 1 internally.
- TOGGLE_INIT, 0: reset value of `dir_toggle`.

Ports:
- clk  input  1  system clock (PLL `outclk_0` domain)
- rst_n  input  1  asynchronous, active-low reset
- btn_raw  input  1  raw asynchronous button/switch pin
- btn_level  output  1  debounced level, 1 = pressed/active
- btn_rise  output  1  one-cycle pulse when `btn_level` goes 0->1
- btn_fall  output  1  one-cycle pulse when `btn_level` goes 1->0
- dir_toggle  output  1  flips on every `btn_rise`
- busy  output  1  high while the FSM is in WAIT_HI or WAIT_LO

Behaviour:
- Clocking and reset:
  - Single clock domain: `clk`.
  - Reset is asynchronous and active-low on `rst_n`. Assertion takes effect immediately, independent of `clk`.
  - Reset values: synchroniser stages 0 (post-inversion), state IDLE_LO, counter 0.
  - Output reset values: `btn_level`=0, `btn_rise`=0, `btn_fall`=0, `busy`=0, `dir_toggle`=TOGGLE_INIT.
- Input path:
  - `in_n = ACTIVE_LOW_IN ? ~btn_raw : btn_raw`.
  - `in_n` passes through SYNC_STAGES flops; the last stage is `s`.
  - Only `s` feeds the FSM.
- Counter:
  - Width is `clog2(DEBOUNCE_CYCLES+1)`.
  - Saturates and never wraps; the compare at DEBOUNCE_CYCLES-1 always fires first.
- FSM transitions, evaluated on each rising `clk` edge:
  - IDLE_LO: if `s`=1, go to WAIT_HI and clear the counter to 0. Otherwise stay.
  - WAIT_HI, `s`=0: go to IDLE_LO and clear the counter. This is a bounce; no pulse.
  - WAIT_HI, `s`=1 and counter==DEBOUNCE_CYCLES-1: go to IDLE_HI. Set `btn_level`=1, pulse `btn_rise`, flip `dir_toggle`.
  - WAIT_HI, `s`=1 otherwise: increment the counter.
  - IDLE_HI: if `s`=0, go to WAIT_LO and clear the counter.
  - WAIT_LO: mirror of WAIT_HI. On success go to IDLE_LO, set `btn_level`=0, pulse `btn_fall`. `dir_toggle` is unchanged.
- Output timing:
  - All outputs are registered.
  - `btn_rise` and `btn_fall` are high for exactly one cycle, in the cycle `btn_level` changes. They are never both high.
  - `busy` = (state==WAIT_HI || state==WAIT_LO), registered alongside the state.
- Latency:
  - Count the first edge that samples the new raw value as edge 1.
  - `btn_level` changes at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Glitch rejection:
  - A raw pulse lasting DEBOUNCE_CYCLES or fewer cycles produces no output change.
  - A raw pulse lasting DEBOUNCE_CYCLES+1 cycles is accepted.
- Boundary cases:
  - Raw held active through reset release: debounces normally after release and yields one `btn_rise`.
  - Reset asserted mid-WAIT: the count is discarded and no pulse is emitted.
  - Reset asserted while a pulse output is high: the pulse clears immediately.
  - Raw input changing every cycle: the FSM oscillates between IDLE_x and WAIT_x; outputs never change.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW_IN=0, TOGGLE_INIT=0. Edge 1 is the first edge sampling the change.
1. Reset hold-active:
   - Stimulus: `rst_n`=0 with `btn_raw`=1.
   - Required during reset: all outputs 0, `dir_toggle`=0.
   - Stimulus: release `rst_n` with `btn_raw` held at 1.
   - Required after release: `btn_level`=1 at edge 11; `btn_rise` high in that cycle only; `dir_toggle`=1.
2. Clean press and release:
   - Stimulus: `btn_raw` 0->1, then held.
   - Required: `btn_level`=1 at edge 11 with a one-cycle `btn_rise`; `busy`=1 for edges 3..10.
   - Stimulus: `btn_raw` 1->0.
   - Required: `btn_level`=0 at edge 11 with a one-cycle `btn_fall`; `dir_toggle` stays 1.
3. Bounce:
   - Stimulus: `btn_raw` high 5 cycles, low 1 cycle, then high held.
   - Required: exactly one `btn_rise`, occurring 11 edges after the final 0->1 transition.
4. Glitch threshold:
   - Stimulus: `btn_raw` high for 8 cycles, then 0.
   - Required: no output change, no pulses.
   - Stimulus: `btn_raw` high for 9 cycles, then 0.
   - Required: one `btn_rise`, later one `btn_fall`.
5. Toggle sequence:
   - Stimulus: 3 clean press/release cycles.
   - Required: `dir_toggle` 0->1->0->1; exactly 3 `btn_rise` and 3 `btn_fall` pulses.
6. Reset mid-debounce:
   - Stimulus: drop `rst_n` during WAIT_HI at counter=5 (`dir_toggle` previously 1).
   - Required: `busy`=0 and `dir_toggle`=0 asynchronously.
   - Stimulus: release `rst_n` with `btn_raw`=1 held.
   - Required: a full 11-edge debounce before `btn_rise`.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, registered level,
// edge pulses and a press-toggled direction bit.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW_IN   = 1'b1,
    parameter bit TOGGLE_INIT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic dir_toggle,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("button_conditioner: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic                   in_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, rise_d, fall_d, toggle_d, busy_d;

    assign in_n = ACTIVE_LOW_IN ? ~btn_raw : btn_raw;
    assign s    = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_n};
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = btn_level;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = dir_toggle;

        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_HI;
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    toggle_d = ~dir_toggle;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase

        // busy is derived from the next state so it is registered alongside it
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_LO;
            cnt_q      <= '0;
            btn_level  <= 1'b0;
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            dir_toggle <= TOGGLE_INIT;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_level  <= level_d;
            btn_rise   <= rise_d;
            btn_fall   <= fall_d;
            dir_toggle <= toggle_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: spec-derived vector table,
// hand-written corner sequences and a run-length reference model under random stimulus.
module tb_button_conditioner;

    localparam int DEB  = 8;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, btn_rise, btn_fall, dir_toggle, busy;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC),
        .ACTIVE_LOW_IN  (1'b0),
        .TOGGLE_INIT    (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .dir_toggle(dir_toggle),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_rise = 0;
    int n_fall = 0;

    // Reference model: s is raw delayed SYNC edges; the level flips once
    // DEB+1 consecutive samples of s disagree with it.
    bit m_q[$];
    bit m_lvl, m_rise, m_fall, m_tog;
    int m_run;

    typedef struct {
        bit         raw;
        logic [4:0] exp;   // {level, rise, fall, toggle, busy}
    } vec_t;
    vec_t vecs[24];

    function automatic logic [4:0] dut_vec();
        return {btn_level, btn_rise, btn_fall, dir_toggle, busy};
    endfunction

    function automatic logic [4:0] model_vec();
        return {m_lvl, m_rise, m_fall, m_tog, (m_run > 0)};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {lvl,rise,fall,tog,busy}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
        m_lvl  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_tog  = 1'b0;
        m_run  = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit samp;
        samp = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(raw);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (samp != m_lvl) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_lvl = samp;
                if (samp) begin
                    m_rise = 1'b1;
                    m_tog  = ~m_tog;
                end else begin
                    m_fall = 1'b1;
                end
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    // One clock edge: update model, sample DUT 1 time unit later, compare.
    task automatic step(input string name);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(btn_raw);
        #1;
        if (btn_rise) n_rise++;
        if (btn_fall) n_fall++;
        check(name, dut_vec(), model_vec());
    endtask

    task automatic do_reset(input bit raw);
        btn_raw = raw;
        rst_n   = 1'b0;
        model_reset();
        step("reset_hold");
        step("reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic hold(input bit raw, input int n, input string name);
        btn_raw = raw;
        for (int i = 0; i < n; i++) step(name);
    endtask

    initial begin
        int r0, f0, edge_at, t0;
        bit tog_seen[3];

        // Clean press then release, expectations written from the latency rules
        for (int e = 1; e <= 12; e++) begin
            vecs[e-1].raw = 1'b1;
            vecs[e-1].exp = {(e >= 11), (e == 11), 1'b0, (e >= 11), (e >= 3 && e <= 10)};
            vecs[e+11].raw = 1'b0;
            vecs[e+11].exp = {(e < 11), 1'b0, (e == 11), 1'b1, (e >= 3 && e <= 10)};
        end

        // 1. raw held active through reset release
        btn_raw = 1'b1;
        rst_n   = 1'b0;
        model_reset();
        #3;
        check("reset_outputs", dut_vec(), 5'b00000);
        step("reset_hold_active");
        rst_n = 1'b1;
        r0 = n_rise;
        edge_at = 0;
        for (int e = 1; e <= 16; e++) begin
            step("t1_release");
            if (btn_rise && edge_at == 0) edge_at = e;
        end
        check_int("t1_rise_edge", edge_at, 11);
        check_int("t1_rise_count", n_rise - r0, 1);
        check("t1_toggle", {4'b0, dir_toggle}, 5'b00001);

        // 2. table-driven clean press and release
        do_reset(1'b0);
        hold(1'b0, 3, "t2_idle");
        for (int i = 0; i < 24; i++) begin
            btn_raw = vecs[i].raw;
            step("t2_model");
            check($sformatf("t2_vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // 3. bounce: high 5, low 1, then high held
        do_reset(1'b0);
        r0 = n_rise;
        hold(1'b1, 5, "t3_bounce");
        hold(1'b0, 1, "t3_bounce");
        btn_raw = 1'b1;
        edge_at = 0;
        for (int e = 1; e <= 20; e++) begin
            step("t3_hold");
            if (btn_rise && edge_at == 0) edge_at = e;
        end
        check_int("t3_rise_edge", edge_at, 11);
        check_int("t3_rise_count", n_rise - r0, 1);

        // 4. glitch threshold: DEB cycles rejected, DEB+1 accepted
        do_reset(1'b0);
        r0 = n_rise; f0 = n_fall;
        hold(1'b1, DEB, "t4_short");
        hold(1'b0, 16, "t4_short_after");
        check_int("t4_short_rises", n_rise - r0, 0);
        check_int("t4_short_falls", n_fall - f0, 0);
        check("t4_short_level", {btn_level, 4'b0}, 5'b00000);
        hold(1'b1, DEB + 1, "t4_long");
        hold(1'b0, 16, "t4_long_after");
        check_int("t4_long_rises", n_rise - r0, 1);
        check_int("t4_long_falls", n_fall - f0, 1);

        // 5. toggle sequence over three presses
        do_reset(1'b0);
        r0 = n_rise; f0 = n_fall;
        check("t5_tog_init", {4'b0, dir_toggle}, 5'b00000);
        for (int p = 0; p < 3; p++) begin
            hold(1'b1, 14, "t5_press");
            tog_seen[p] = dir_toggle;
            hold(1'b0, 14, "t5_release");
        end
        check("t5_tog_seq", {2'b0, tog_seen[0], tog_seen[1], tog_seen[2]}, 5'b00101);
        check_int("t5_rises", n_rise - r0, 3);
        check_int("t5_falls", n_fall - f0, 3);

        // 6. reset during WAIT_HI at counter 5 with dir_toggle already 1
        do_reset(1'b0);
        hold(1'b1, 14, "t6_setup");
        hold(1'b0, 14, "t6_setup");
        hold(1'b1, SYNC + 1 + 5, "t6_wait");
        check("t6_busy_before", {busy, dir_toggle, 3'b0}, 5'b11000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_clear", dut_vec(), 5'b00000);
        step("t6_in_reset");
        step("t6_in_reset");
        rst_n = 1'b1;
        r0 = n_rise;
        edge_at = 0;
        for (int e = 1; e <= 16; e++) begin
            step("t6_after");
            if (btn_rise && edge_at == 0) edge_at = e;
        end
        check_int("t6_rise_edge", edge_at, 11);
        check_int("t6_rise_count", n_rise - r0, 1);

        // reset while btn_fall is high clears it at once
        btn_raw = 1'b0;
        t0 = 0;
        for (int e = 1; e <= 30 && t0 == 0; e++) begin
            step("t6_fall_wait");
            if (btn_fall) t0 = e;
        end
        check_int("t6_fall_seen", t0, 11);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_pulse_clear", dut_vec(), 5'b00000);
        step("t6_in_reset2");
        rst_n = 1'b1;

        // raw changing every cycle: outputs never move
        do_reset(1'b0);
        r0 = n_rise; f0 = n_fall;
        for (int i = 0; i < 40; i++) begin
            btn_raw = i[0];
            step("alt_model");
        end
        check_int("alt_no_pulses", (n_rise - r0) + (n_fall - f0), 0);
        check("alt_level", {btn_level, 4'b0}, 5'b00000);

        // randomized hold lengths against the model
        do_reset(1'b0);
        for (int k = 0; k < 150; k++) begin
            hold(k[0] ? 1'b0 : 1'b1, int'($urandom_range(1, 14)), "rand_model");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
